csa_pipe: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor. It is the next generation of the team's 32-bit combinational carry-select adder.
- Generalised in operand width and carry-select block size.
- Adds add/subtract mode, a signed-overflow flag, and a registered pipeline with a valid/ready handshake on both sides.
- Sits in datapaths that need a high-Fmax adder with back-pressure, e.g. accumulators and address generators.

---
 rtl/csa_pkg.sv | 15 +
 rtl/csa_block.sv | 24 ++
 rtl/csa_pipe.sv | 127 ++++++++++++
 tb/tb_csa_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-select adder.
package csa_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Pipeline depth; 0 flags an illegal WIDTH/BLK pairing so the top can refuse to elaborate.
    function automatic int unsigned csa_nstage(input int unsigned width, input int unsigned blk);
        if (blk == 0 || width == 0 || (width % blk) != 0) begin
            return 0;
        end
        return width / blk;
    endfunction

endpackage

// File: rtl/csa_block.sv
// Combinational BLK-bit carry-select cell: both carry-in hypotheses computed, cin picks one.
module csa_block #(
    parameter int unsigned BLK = 8
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout,
    output logic           cmsb
);

    logic [BLK:0] sum0;
    logic [BLK:0] sum1;

    assign sum0 = {1'b0, a} + {1'b0, b};
    assign sum1 = {1'b0, a} + {1'b0, b} + (BLK+1)'(1);

    assign {cout, s} = cin ? sum1 : sum0;

    // Carry into the top bit recovered from the sum bit: s = a ^ b ^ c.
    assign cmsb = s[BLK-1] ^ a[BLK-1] ^ b[BLK-1];

endmodule

// File: rtl/csa_pipe.sv
// Pipelined carry-select adder/subtractor, one BLK-bit block per stage, valid/ready on both sides.
module csa_pipe
    import csa_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLK   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSTAGE = csa_nstage(WIDTH, BLK);

    if (NSTAGE == 0) begin : g_bad_cfg
        $error("csa_pipe: WIDTH must be a nonzero multiple of BLK");
    end

    logic             en;
    logic [WIDTH-1:0] b_ent;
    logic             c_ent;

    // Whole pipeline advances together; it only stalls when a result is stuck at the output.
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    assign b_ent = (sub == MODE_SUB) ? ~b : b;
    assign c_ent = (sub == MODE_ADD) ? cin : 1'b1;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
        // Operand bits not yet consumed when data reaches stage k.
        localparam int unsigned WOP = WIDTH - k * BLK;

        logic [WOP-1:0]       opa;
        logic [WOP-1:0]       opb;
        logic [(k+1)*BLK-1:0] s_nxt;
        logic [(k+1)*BLK-1:0] s_q;
        logic [BLK-1:0]       blk_s;
        logic                 blk_cin;
        logic                 blk_cout;
        logic                 blk_cmsb;
        logic                 vin;
        logic                 v_q;
        logic                 c_q;

        if (k == 0) begin : g_src
            assign opa     = a;
            assign opb     = b_ent;
            assign blk_cin = c_ent;
            assign vin     = in_valid;
            assign s_nxt   = blk_s;
        end else begin : g_src
            assign opa     = g_stg[k-1].g_skew.opa_q;
            assign opb     = g_stg[k-1].g_skew.opb_q;
            assign blk_cin = g_stg[k-1].c_q;
            assign vin     = g_stg[k-1].v_q;
            assign s_nxt   = {blk_s, g_stg[k-1].s_q};
        end

        csa_block #(.BLK(BLK)) u_blk (
            .a    (opa[BLK-1:0]),
            .b    (opb[BLK-1:0]),
            .cin  (blk_cin),
            .s    (blk_s),
            .cout (blk_cout),
            .cmsb (blk_cmsb)
        );

        // Stage valid, inter-block carry and de-skewed low sum slices.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= vin;
                c_q <= blk_cout;
                s_q <= s_nxt;
            end
        end

        if (k < NSTAGE - 1) begin : g_skew
            logic [WOP-BLK-1:0] opa_q;
            logic [WOP-BLK-1:0] opb_q;
            logic               cmsb_unused;

            assign cmsb_unused = blk_cmsb;

            // Upper operand slices wait here until their block's carry is ready.
            always_ff @(posedge clk) begin
                if (rst) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (en) begin
                    opa_q <= opa[WOP-1:BLK];
                    opb_q <= opb[WOP-1:BLK];
                end
            end
        end else begin : g_last
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= blk_cmsb ^ blk_cout;
                end
            end
        end
    end

    assign out_valid = g_stg[NSTAGE-1].v_q;
    assign sum       = g_stg[NSTAGE-1].s_q;
    assign cout      = g_stg[NSTAGE-1].c_q;
    assign ovf       = g_stg[NSTAGE-1].g_last.ovf_q;

endmodule

// File: tb/tb_csa_pipe.sv
// Scoreboard bench for csa_pipe: three configurations (32/8, 16/4, 32/32) checked against an arithmetic model.
module tb_csa_pipe;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          stamp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_ready;
    logic        cin;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  iv;

    logic        ir0, ov0, co0, of0;
    logic        ir1, ov1, co1, of1;
    logic        ir2, ov2, co2, of2;
    logic [31:0] s0;
    logic [15:0] s1;
    logic [31:0] s2;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   emitted [3];
    logic shown [3];
    logic lat_chk;
    logic done;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic [31:0] va [6] = '{32'h0, 32'hFFFF_FFFF, 32'h5, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] vb [6] = '{32'h1, 32'hFFFF_FFFF, 32'h8, 32'hFFFF_FFFF, 32'h1, 32'h1};
    logic        vc [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        vs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csa_pipe #(.WIDTH(32), .BLK(8)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov0), .out_ready(out_ready), .sum(s0), .cout(co0), .ovf(of0)
    );
    csa_pipe #(.WIDTH(16), .BLK(4)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1), .ovf(of1)
    );
    csa_pipe #(.WIDTH(32), .BLK(32)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov2), .out_ready(out_ready), .sum(s2), .cout(co2), .ovf(of2)
    );

    function automatic int dut_w(input int d);
        return (d == 1) ? 16 : 32;
    endfunction

    function automatic int dut_lat(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t ref_model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                       input logic ci, input logic sb);
        longint mask, half, ua, ub, sa, sbv, ures, sres;
        exp_t   e;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sbv  = (ub >= half) ? ub - 2 * half : ub;
        if (sb) begin
            ures   = ua - ub;
            sres   = sa - sbv;
            e.cout = (ua >= ub);
        end else begin
            ures   = ua + ub + longint'(ci);
            sres   = sa + sbv + longint'(ci);
            e.cout = (ures > mask);
        end
        e.sum   = 32'(ures & mask);
        e.ovf   = (sres >= half) || (sres < -half);
        e.stamp = 0;
        return e;
    endfunction

    function automatic int q_size(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t q_front(input int d);
        case (d)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic q_push(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic q_pop(input int d);
        case (d)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    function automatic logic ready_of(input int d);
        case (d)
            0:       return ir0;
            1:       return ir1;
            default: return ir2;
        endcase
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s dut%0d: got %h, expected %h (cycle %0d)", name, d, got, want, cyc);
        end
    endtask

    // Compare the presented result with the oldest pending expectation; retire it on handshake.
    task automatic mon(input int d, input logic v, input logic [31:0] s, input logic c, input logic o);
        exp_t e;
        if (!v) return;
        if (q_size(d) == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result dut%0d: got sum %h with nothing pending (cycle %0d)", d, s, cyc);
            return;
        end
        e = q_front(d);
        chk("sum", d, s, e.sum);
        chk("cout", d, 32'(c), 32'(e.cout));
        chk("ovf", d, 32'(o), 32'(e.ovf));
        if (lat_chk && !shown[d]) chk("latency", d, 32'(cyc - e.stamp), 32'(dut_lat(d)));
        if (out_ready) begin
            q_pop(d);
            emitted[d]++;
            shown[d] = 1'b0;
        end else begin
            shown[d] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, ov0, s0, co0, of0);
            mon(1, ov1, 32'(s1), co1, of1);
            mon(2, ov2, s2, co2, of2);
        end
    end

    // Called and returns just after a rising edge; expectation queued once the transfer is certain.
    task automatic send(input int d, input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb);
        exp_t e;
        int   guard;
        logic ok;
        a     = av;
        b     = bv;
        cin   = ci;
        sub   = sb;
        iv[d] = 1'b1;
        guard = 0;
        ok    = 1'b0;
        while (!ok && guard < 200) begin
            @(negedge clk);
            ok = ready_of(d);
            guard++;
        end
        if (ok) begin
            e       = ref_model(dut_w(d), av, bv, ci, sb);
            e.stamp = cyc;
            q_push(d, e);
        end else begin
            tests++;
            fails++;
            $display("FAIL send_timeout dut%0d: in_ready stayed 0, required 1", d);
            iv[d] = 1'b0;
        end
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
    endtask

    task automatic wait_empty();
        int g;
        g = 0;
        while ((q_size(0) + q_size(1) + q_size(2)) != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("drain_pending", 0, 32'(q_size(0) + q_size(1) + q_size(2)), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        iv        = '0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        lat_chk   = 1'b0;
        done      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            emitted[i] = 0;
            shown[i]   = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 0, 32'(ov0), 32'd0);
        chk("rst_sum", 0, s0, 32'd0);
        chk("rst_in_ready", 0, 32'(ir0), 32'd1);
        chk("rst_out_valid", 1, 32'(ov1), 32'd0);
        chk("rst_out_valid", 2, 32'(ov2), 32'd0);
        @(posedge clk);
        #1;

        // Directed add/sub vectors back-to-back on every configuration.
        lat_chk = 1'b1;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 6; i++) send(d, va[i], vb[i], vc[i], vs[i]);
            wait_empty();
        end

        // Random stream with a three-cycle downstream stall in the middle.
        lat_chk = 1'b0;
        base    = emitted[0];
        fork
            begin
                for (int i = 0; i < 10; i++) send(0, $urandom, $urandom, 1'($urandom), 1'($urandom));
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 0, 32'(ir0), 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_empty();
        chk("stream_count", 0, 32'(emitted[0] - base), 32'd10);

        // Random traffic with bubbles and random back-pressure.
        for (int d = 0; d < 3; d++) begin
            done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 25; i++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                        send(d, $urandom, $urandom, 1'($urandom), 1'($urandom));
                    end
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        @(posedge clk);
                        #1;
                        out_ready = ($urandom_range(0, 2) != 0);
                    end
                    out_ready = 1'b1;
                end
            join
            wait_empty();
        end

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++) send(0, $urandom, $urandom, 1'($urandom), 1'($urandom));
        rst = 1'b1;
        q0.delete();
        q1.delete();
        q2.delete();
        for (int i = 0; i < 3; i++) shown[i] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 0, 32'(ov0), 32'd0);
        chk("flush_in_ready", 0, 32'(ir0), 32'd1);
        @(posedge clk);
        #1;
        lat_chk = 1'b1;
        send(0, 32'd4, 32'd8, 1'b1, 1'b0);
        wait_empty();
        repeat (8) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
